// File: rtl/redstone_pkg.sv
// redstone_pkg: shared redstone types and game timing constants.
package redstone_pkg;
  typedef bit [3:0] redstone;
  localparam int REDSTONE_MAX = 15;
  localparam int HOPPER_COOLDOWN = 8;
  localparam int GAME_TICKS_PER_REDSTONE_TICK = 2;
endpackage

// File: rtl/hopper_if.sv
// hopper_if: item handshakes plus lock and fill-level signals around a hopper.
interface hopper_if #(parameter int CAPACITY = 320) ();
  import redstone_pkg::*;
  localparam int CW = $clog2(CAPACITY + 1);
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  redstone lock;
  redstone level;
  logic [CW-1:0] count;
  modport master (output in_valid, out_ready, lock, input in_ready, out_valid, level, count);
  modport slave (input in_valid, out_ready, lock, output in_ready, out_valid, level, count);
endinterface

// File: rtl/fill_level.sv
// fill_level: container item count to comparator strength, 0 when empty else 1 + floor(14*count/CAPACITY).
module fill_level
  import redstone_pkg::*;
#(
  parameter int CAPACITY = 320,
  localparam int CW = $clog2(CAPACITY + 1),
  localparam int PW = $clog2(14 * CAPACITY + 1)
) (
  input  logic [CW-1:0] count,
  output redstone       level
);
  logic [PW-1:0] prod;
  logic [PW-1:0] q;
  assign prod = PW'(count) * PW'(14);
  assign q = prod / PW'(CAPACITY);
  assign level = (count == '0) ? redstone'(0) : redstone'(4'(q) + 4'd1);
endmodule

// File: rtl/hopper.sv
// hopper: item buffer with rate-limited, lockable output and a registered fill-level strength.
module hopper
  import redstone_pkg::*;
#(
  parameter int CAPACITY = 320,
  parameter int COOLDOWN = HOPPER_COOLDOWN
) (
  input logic       clk,
  input logic       rst_n,
  hopper_if.slave   bus
);
  localparam int CW = $clog2(CAPACITY + 1);
  localparam int CDW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CDW-1:0] cd;
  logic [CDW-1:0] cd_next;
  redstone level;
  redstone level_next;
  logic push;
  logic pull;
  assign bus.in_ready = count < CW'(CAPACITY);
  assign bus.out_valid = (count != '0) && (bus.lock == '0) && (cd == '0);
  assign bus.count = count;
  assign bus.level = level;
  assign push = bus.in_valid && bus.in_ready;
  assign pull = bus.out_valid && bus.out_ready;
  always_comb begin
    count_next = (push && !pull) ? count + CW'(1) : (pull && !push) ? count - CW'(1) : count;
    // waking an empty hopper costs a full cooldown before the first transfer
    cd_next = (pull || (push && count == '0)) ? CDW'(COOLDOWN - 1) : (cd != '0) ? cd - CDW'(1) : cd;
  end
  fill_level #(.CAPACITY(CAPACITY)) u_fill (.count(count_next), .level(level_next));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      cd <= '0;
      level <= '0;
    end else begin
      count <= count_next;
      cd <= cd_next;
      level <= level_next;
    end
  end
endmodule

// File: tb/tb_hopper.sv
// tb_hopper: table-driven, directed and randomized checks of hopper against a tick-level model.
module tb_hopper;
  localparam int CAP = 320;
  localparam int COOL = 8;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  int m_cnt;
  int m_rdy;
  int cyc = 0;
  logic dut_pull;
  hopper_if #(.CAPACITY(CAP)) bus ();
  hopper #(.CAPACITY(CAP), .COOLDOWN(COOL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int lvl;
    int ir;
  } lvl_vec_t;
  lvl_vec_t tbl[6];

  always @(negedge clk)
    if (rst_n) assert (int'(bus.count) <= CAP) else $error("count overflow %0d", bus.count);

  function automatic int lvl_of(int c);
    return (c == 0) ? 0 : 1 + (14 * c) / CAP;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // one tick: drive inputs, compare outputs with the model, then advance both across the edge
  task automatic tick(input logic iv, input logic orr, input logic [3:0] lk);
    int e_ir, e_ov;
    logic push, pull;
    bus.in_valid = iv;
    bus.out_ready = orr;
    bus.lock = lk;
    #1;
    e_ir = (m_cnt < CAP) ? 1 : 0;
    e_ov = (m_cnt != 0 && lk == 0 && cyc >= m_rdy) ? 1 : 0;
    chk("in_ready", int'(bus.in_ready), e_ir);
    chk("out_valid", int'(bus.out_valid), e_ov);
    chk("count", int'(bus.count), m_cnt);
    chk("level", int'(bus.level), lvl_of(m_cnt));
    dut_pull = bus.out_valid && orr;
    push = iv && (e_ir != 0);
    pull = (e_ov != 0) && orr;
    @(posedge clk);
    if (pull || (push && m_cnt == 0)) m_rdy = cyc + COOL;
    m_cnt = m_cnt + int'(push) - int'(pull);
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.lock = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1;
    m_cnt = 0;
    m_rdy = 0;
  endtask

  initial begin
    int pe, k, np, last, gmin, gmax, pw;
    logic iv, orr;
    logic [3:0] lk;
    tbl[0] = '{1, 1, 1};
    tbl[1] = '{22, 1, 1};
    tbl[2] = '{23, 2, 1};
    tbl[3] = '{160, 8, 1};
    tbl[4] = '{319, 14, 1};
    tbl[5] = '{320, 15, 0};
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.lock = 0;
    m_cnt = 0;
    m_rdy = 0;
    #3;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    reset_dut();

    pe = cyc;
    tick(1, 0, 0);
    chk("push1_count", int'(bus.count), 1);
    chk("push1_level", int'(bus.level), 1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick(0, 0, 0);
      k++;
    end
    chk("first_pull_delay", cyc - pe, COOL);

    foreach (tbl[i]) begin
      while (m_cnt < tbl[i].n) tick(1, 0, 3);
      chk("tbl_count", int'(bus.count), tbl[i].n);
      chk("tbl_level", int'(bus.level), tbl[i].lvl);
      chk("tbl_in_ready", int'(bus.in_ready), tbl[i].ir);
    end

    tick(1, 1, 0);
    chk("full_pull_count", int'(bus.count), 319);
    tick(1, 0, 0);
    chk("full_refill_count", int'(bus.count), 320);
    chk("full_cd_blocks", int'(bus.out_valid), 0);

    reset_dut();
    repeat (10) tick(1, 0, 0);
    np = 0;
    last = -1;
    gmin = 1000;
    gmax = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, 0);
      if (dut_pull) begin
        if (last >= 0) begin
          gmin = (i - last < gmin) ? i - last : gmin;
          gmax = (i - last > gmax) ? i - last : gmax;
        end
        last = i;
        np++;
      end
    end
    chk("rate_pulls", np, 5);
    chk("rate_gap_min", gmin, COOL);
    chk("rate_gap_max", gmax, COOL);
    chk("rate_count", int'(bus.count), 5);
    chk("rate_level", int'(bus.level), 1);

    chk("pre_lock_valid", int'(bus.out_valid), 1);
    bus.lock = 3;
    #1;
    chk("lock_drop", int'(bus.out_valid), 0);
    tick(1, 1, 3);
    chk("lock_no_pull", int'(dut_pull), 0);
    chk("lock_fills", int'(bus.count), 6);
    repeat (9) tick(0, 1, 3);
    bus.lock = 0;
    #1;
    chk("unlock_raise", int'(bus.out_valid), 1);
    tick(0, 0, 0);

    for (int b = 0; b < 6; b++) begin
      pw = (b % 3 == 0) ? 95 : (b % 3 == 1) ? 50 : 10;
      for (int i = 0; i < 500; i++) begin
        iv = ($urandom_range(0, 99) < pw);
        orr = ($urandom_range(0, 99) < 60);
        lk = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        tick(iv, orr, lk);
      end
    end

    reset_dut();
    while (m_cnt < 51) tick(1, 0, 3);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick(0, 0, 0);
      k++;
    end
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("mid_pre_count", int'(bus.count), 50);
    chk("mid_pre_cd", int'(dut.cd), 5);
    bus.in_valid = 1;
    bus.out_ready = 1;
    #2;
    rst_n = 0;
    #1;
    chk("mid_count", int'(bus.count), 0);
    chk("mid_cd", int'(dut.cd), 0);
    chk("mid_level", int'(bus.level), 0);
    chk("mid_out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("mid_no_hs", int'(bus.count), 0);
    rst_n = 1;
    m_cnt = 0;
    m_rdy = 0;
    cyc++;
    tick(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hopper.md
# hopper

Item buffer that sits directly upstream of the comparator: it holds a count of items, accepts items from an upstream source, passes them downstream at the game's transfer rate, and publishes its fill level as a redstone strength. That strength drives a comparator's back input. A nonzero redstone signal on the lock input stops output transfers, the same as a powered hopper. One clk cycle equals one game tick.

## Interface
Parameters:
- CAPACITY, 320 — maximum item count (5 slots × 64); must be ≥ 1.
- COOLDOWN, 8 — minimum number of cycles between two output transfers; must be ≥ 1.

Ports:
- clk  input  1  game-tick clock.
- rst_n  input  1  reset; **one clock; reset is asynchronous and active-low.**
- in_valid  input  1  upstream offers one item.
- in_ready  output  1  hopper can accept one item.
- out_valid  output  1  hopper offers one item downstream.
- out_ready  input  1  downstream can take one item.
- lock  input  redstone (4)  lock signal; any nonzero value locks the hopper.
- level  output  redstone (4)  fill-level strength for the comparator.
- count  output  $clog2(CAPACITY+1)  current item count.

## Operation
- State registers: `count`, the cooldown counter `cd`, and the `level` register.
- Push:
  - in_ready = (count < CAPACITY). It is combinational from the registered count.
  - A push happens when in_valid && in_ready.
- Pull:
  - out_valid = (count != 0) && (lock == 0) && (cd == 0).
  - A pull happens when out_valid && out_ready.
- count_next = count + push − pull.
  - A simultaneous push and pull leaves count unchanged.
  - There is no bypass. When count == CAPACITY, in_ready is 0 even if a pull happens in the same cycle.
  - When count == 0, out_valid is 0 even if a push happens in the same cycle.
- Cooldown:
  - A pull loads cd = COOLDOWN − 1.
  - A push while count == 0 loads cd = COOLDOWN − 1.
  - Otherwise cd decrements when nonzero, then holds at 0.
  - cd keeps counting while the hopper is locked. Lock gates only out_valid.
- Lock:
  - Lock does not affect in_ready. A locked hopper still fills.
  - A lock change takes effect in the same cycle, because out_valid is combinational from lock.
- Level:
  - level is registered from count_next, so it always matches count.
  - level = 0 if count == 0; otherwise level = 1 + floor(14·count / CAPACITY).
  - Range is 0..15. level = 15 only when count == CAPACITY.
  - Intermediate product width is at least $clog2(14·CAPACITY+1).
- count never underflows or overflows. The handshake makes both impossible, and the verifier asserts this.

## Timing
- Reset values (asynchronous, while rst_n = 0): count = 0, cd = 0, level = 0. The resulting outputs are in_ready = 1 and out_valid = 0.
- Reset asserted mid-transfer: the in-flight handshake is discarded, and every register returns to its reset value immediately.
- Push latency: a push at edge t makes count and level change at t+1.
- First pull after a push into an empty hopper: a push at edge t gives out_valid = 1 at cycle t+COOLDOWN at the earliest.
- Pull spacing: a pull at edge t gives the next out_valid no earlier than t+COOLDOWN, so the sustained rate is one item per COOLDOWN cycles.
- Lock timing:
  - Asserting lock drops out_valid in the same cycle. A handshake is never accepted while lock ≠ 0.
  - Releasing lock with cd == 0 raises out_valid in the same cycle.
- COOLDOWN = 1: cd stays at 0, so a pull is possible every cycle.

## Structure
- Shared package `redstone_pkg` holds:
  - `typedef bit [3:0] redstone`
  - `REDSTONE_MAX = 15`
  - `HOPPER_COOLDOWN = 8`
  - `GAME_TICKS_PER_REDSTONE_TICK = 2`
- Sub-module `fill_level`: combinational (count, CAPACITY) → redstone, implementing the level formula.
  - The comparator's container-read path reuses it.
- Top level holds the count, cooldown and handshake logic, plus the level register.

## Test plan
- **Reset and fill:** hold rst_n = 0, then release; push 1 item → after reset, count = 0, level = 0, in_ready = 1, out_valid = 0. One cycle after the push, count = 1 and level = 1; out_valid rises exactly 8 cycles after the push edge.
- **Level steps (CAPACITY = 320):**
  - count 22 → level 1.
  - count 23 → level 2.
  - count 319 → level 14.
  - count 320 → level 15, and in_ready = 0.
- **Full with simultaneous events:** at count = 320, hold in_valid = 1 and pull one item → no push is accepted that cycle, and count = 319. The next cycle in_ready = 1, and a push returns count to 320 while the cooldown blocks pulls.
- **Rate limit:** fill to 10, then hold out_ready = 1 for 40 cycles → exactly 5 pulls, spaced 8 cycles apart; count = 5 and level = 1.
- **Lock:**
  - Set lock = 3 while out_valid = 1 → out_valid = 0 in the same cycle and no pull occurs; pushes are still accepted.
  - After lock has been held for more than 8 cycles, set lock = 0 → out_valid = 1 in the same cycle.
- **Reset mid-operation:** with count = 50 and cd = 5, pulse rst_n low in the middle of a cycle → count, cd and level read 0 immediately, and no handshake completes in that cycle.
